// File: rtl/dif_radix2_64p_loader.sv
// Input loader for the 64-point radix-2 DIF data array: turns a natural-order
// sample stream into one-hot bank writes and flags each completed 64-sample frame.
module dif_radix2_64p_loader #(
    parameter int unsigned DATA_WIDTH  = 17,
    parameter int unsigned NUM_BANKS   = 8,
    parameter int unsigned BANK_DEPTH  = 8,
    parameter int unsigned BIT_REVERSE = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_real,
    input  logic [DATA_WIDTH-1:0]         in_imag,
    input  logic                          in_last,
    output logic [NUM_BANKS-1:0]          wen_ctrl,
    output logic [$clog2(BANK_DEPTH)-1:0] waddr_ctrl,
    output logic [DATA_WIDTH-1:0]         din_real,
    output logic [DATA_WIDTH-1:0]         din_imag,
    output logic                          frame_valid,
    input  logic                          frame_ack,
    output logic [5:0]                    sample_cnt,
    output logic                          err_len
);

    localparam int unsigned ADDR_W = $clog2(BANK_DEPTH);
    localparam int unsigned BANK_W = $clog2(NUM_BANKS);
    localparam int unsigned IDX_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic                    accept;
    logic [IDX_W-1:0]        idx;
    logic                    in_ready_d;
    logic                    frame_valid_d;
    logic [NUM_BANKS-1:0]    wen_d;
    logic [ADDR_W-1:0]       waddr_d;
    logic [DATA_WIDTH-1:0]   din_real_d;
    logic [DATA_WIDTH-1:0]   din_imag_d;
    logic [5:0]              sample_cnt_d;
    logic                    err_len_d;

    function automatic logic [IDX_W-1:0] bitrev6(input logic [IDX_W-1:0] n);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(IDX_W); i++) begin
            r[IDX_W-1-i] = n[i];
        end
        return r;
    endfunction

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            wen_ctrl    <= '0;
            waddr_ctrl  <= '0;
            din_real    <= '0;
            din_imag    <= '0;
            frame_valid <= 1'b0;
            sample_cnt  <= '0;
            err_len     <= 1'b0;
        end else begin
            state       <= next_state;
            in_ready    <= in_ready_d;
            wen_ctrl    <= wen_d;
            waddr_ctrl  <= waddr_d;
            din_real    <= din_real_d;
            din_imag    <= din_imag_d;
            frame_valid <= frame_valid_d;
            sample_cnt  <= sample_cnt_d;
            err_len     <= err_len_d;
        end
    end

    // in_ready is high exactly while in LOAD, so it doubles as the accept qualifier.
    always_comb begin
        accept     = in_valid & in_ready;
        next_state = state;
        case (state)
            IDLE: if (enable) next_state = LOAD;
            LOAD: if (accept && sample_cnt == 6'd63) next_state = FULL;
            FULL: if (frame_ack) next_state = enable ? LOAD : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs; write lands one cycle after accept.
    always_comb begin
        idx           = (BIT_REVERSE != 0) ? bitrev6(sample_cnt) : sample_cnt;
        in_ready_d    = (next_state == LOAD);
        frame_valid_d = (next_state == FULL);
        wen_d         = '0;
        waddr_d       = waddr_ctrl;
        din_real_d    = din_real;
        din_imag_d    = din_imag;
        sample_cnt_d  = sample_cnt;
        err_len_d     = err_len;
        if (accept) begin
            wen_d[idx[IDX_W-1 -: BANK_W]] = 1'b1;
            waddr_d      = idx[ADDR_W-1:0];
            din_real_d   = in_real;
            din_imag_d   = in_imag;
            sample_cnt_d = sample_cnt + 6'd1;
            if (in_last != (sample_cnt == 6'd63)) begin
                err_len_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dif_radix2_64p_loader.sv
// Scoreboard bench for dif_radix2_64p_loader: natural and bit-reversed instances
// share stimulus; a frame-level model predicts writes and status outputs.
module tb_dif_radix2_64p_loader;

    localparam int DW = 17;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          frame_ack = 1'b0;
    logic [DW-1:0] in_real = '0;
    logic [DW-1:0] in_imag = '0;

    logic          ready0, ready1, fv0, fv1, err0, err1;
    logic [7:0]    wen0, wen1;
    logic [2:0]    waddr0, waddr1;
    logic [DW-1:0] dr0, dr1, di0, di1;
    logic [5:0]    cnt0, cnt1;

    always #5 clk = ~clk;

    dif_radix2_64p_loader #(.DATA_WIDTH(DW), .NUM_BANKS(8), .BANK_DEPTH(8), .BIT_REVERSE(0)) u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(ready0),
        .in_real(in_real), .in_imag(in_imag), .in_last(in_last), .wen_ctrl(wen0),
        .waddr_ctrl(waddr0), .din_real(dr0), .din_imag(di0), .frame_valid(fv0),
        .frame_ack(frame_ack), .sample_cnt(cnt0), .err_len(err0)
    );

    dif_radix2_64p_loader #(.DATA_WIDTH(DW), .NUM_BANKS(8), .BANK_DEPTH(8), .BIT_REVERSE(1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(ready1),
        .in_real(in_real), .in_imag(in_imag), .in_last(in_last), .wen_ctrl(wen1),
        .waddr_ctrl(waddr1), .din_real(dr1), .din_imag(di1), .frame_valid(fv1),
        .frame_ack(frame_ack), .sample_cnt(cnt1), .err_len(err1)
    );

    typedef struct {
        int            due;
        logic [7:0]    wen;
        logic [2:0]    addr;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];
    wr_t e0, e1;
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    // Model: phase 0 = waiting for enable, 1 = loading, 2 = frame held.
    int            m_phase = 0;
    int            m_cnt = 0;
    logic          m_err = 1'b0;
    logic          m_init = 1'b0;
    int            m_addr0 = 0;
    int            m_addr1 = 0;
    logic [DW-1:0] m_re = '0;
    logic [DW-1:0] m_im = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int brev6(input int n);
        int r = 0;
        for (int i = 0; i < 6; i++) begin
            if (((n >> i) & 1) != 0) r += (1 << (5 - i));
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (q0.size() > 0 && q0[0].due < cyc) begin
            chk("wr0_missing", 32'(cyc), 32'(q0[0].due));
            void'(q0.pop_front());
        end
        if (wen0 != 8'h00) begin
            if (q0.size() == 0) chk("wr0_unexpected", 32'(wen0), 32'h0);
            else begin
                e0 = q0.pop_front();
                chk("wr0_time", 32'(cyc), 32'(e0.due));
                chk("wr0_wen", 32'(wen0), 32'(e0.wen));
                chk("wr0_addr", 32'(waddr0), 32'(e0.addr));
                chk("wr0_re", 32'(dr0), 32'(e0.re));
                chk("wr0_im", 32'(di0), 32'(e0.im));
            end
        end
    end

    always @(negedge clk) begin
        if (q1.size() > 0 && q1[0].due < cyc) begin
            chk("wr1_missing", 32'(cyc), 32'(q1[0].due));
            void'(q1.pop_front());
        end
        if (wen1 != 8'h00) begin
            if (q1.size() == 0) chk("wr1_unexpected", 32'(wen1), 32'h0);
            else begin
                e1 = q1.pop_front();
                chk("wr1_time", 32'(cyc), 32'(e1.due));
                chk("wr1_wen", 32'(wen1), 32'(e1.wen));
                chk("wr1_addr", 32'(waddr1), 32'(e1.addr));
                chk("wr1_re", 32'(dr1), 32'(e1.re));
                chk("wr1_im", 32'(di1), 32'(e1.im));
            end
        end
    end

    // One clock: check status against the model, drive inputs, advance the model.
    task automatic step(input logic r, input logic en, input logic v, input logic last,
                        input logic ack, input logic [DW-1:0] re, input logic [DW-1:0] im);
        int  idx, bidx;
        wr_t w;
        if (m_init) begin
            chk("ready0", 32'(ready0), 32'(m_phase == 1));
            chk("ready1", 32'(ready1), 32'(m_phase == 1));
            chk("fvalid0", 32'(fv0), 32'(m_phase == 2));
            chk("fvalid1", 32'(fv1), 32'(m_phase == 2));
            chk("cnt0", 32'(cnt0), 32'(m_cnt));
            chk("cnt1", 32'(cnt1), 32'(m_cnt));
            chk("err0", 32'(err0), 32'(m_err));
            chk("err1", 32'(err1), 32'(m_err));
            chk("waddr0", 32'(waddr0), 32'(m_addr0));
            chk("waddr1", 32'(waddr1), 32'(m_addr1));
            chk("din_re0", 32'(dr0), 32'(m_re));
            chk("din_im1", 32'(di1), 32'(m_im));
        end
        rst = r; enable = en; in_valid = v; in_last = last; frame_ack = ack;
        in_real = re; in_imag = im;
        if (r) begin
            m_phase = 0; m_cnt = 0; m_err = 1'b0; m_init = 1'b1;
            m_addr0 = 0; m_addr1 = 0; m_re = '0; m_im = '0;
        end else begin
            case (m_phase)
                0: if (en) m_phase = 1;
                1: if (v) begin
                    idx  = m_cnt;
                    bidx = brev6(m_cnt);
                    w.due = cyc + 1; w.re = re; w.im = im;
                    w.wen = 8'(1 << (idx / 8)); w.addr = 3'(idx % 8);
                    q0.push_back(w);
                    w.wen = 8'(1 << (bidx / 8)); w.addr = 3'(bidx % 8);
                    q1.push_back(w);
                    m_addr0 = idx % 8; m_addr1 = bidx % 8; m_re = re; m_im = im;
                    if (last != (m_cnt == 63)) m_err = 1'b1;
                    if (m_cnt == 63) begin
                        m_cnt = 0; m_phase = 2;
                    end else m_cnt++;
                end
                default: if (ack) m_phase = en ? 1 : 0;
            endcase
        end
        @(negedge clk);
    endtask

    // mode 0: n as data, valid held; 1: random valid/enable; 2: early in_last at 30; 3: stop after 20
    task automatic run_frame(input int mode);
        int            guard = 0;
        int            acc = 0;
        logic          v, last, en;
        logic [DW-1:0] re, im;
        while (m_phase == 1 && guard < 2000 && !(mode == 3 && acc >= 20)) begin
            if (mode == 1) begin
                v  = (guard < 4) ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
                en = 1'($urandom_range(0, 1));
            end else begin
                v  = 1'b1;
                en = 1'b1;
            end
            last = (mode == 2) ? (m_cnt == 30 || m_cnt == 63) : (m_cnt == 63);
            re   = (mode == 0) ? DW'(m_cnt) : DW'($urandom);
            im   = (mode == 0) ? DW'(m_cnt) : DW'($urandom);
            if (v) acc++;
            step(1'b0, en, v, last, 1'b0, re, im);
            guard++;
        end
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        run_frame(0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, DW'($urandom), DW'($urandom));
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, DW'($urandom), DW'($urandom));
        run_frame(1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, '0, '0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), '0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        run_frame(2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
        run_frame(3);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        run_frame(0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("q0_drain", 32'(q0.size()), 32'h0);
        chk("q1_drain", 32'(q1.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dif_radix2_64p_loader.md
Name: dif_radix2_64p_loader

Overview:
- Input stage that sits directly upstream of the 64-point radix-2 DIF data array.
- Accepts a stream of complex samples in natural order over a valid/ready handshake and converts each into a one-hot bank write: wen_ctrl, waddr_ctrl, din_real and din_imag.
- After the 64th sample it holds a frame-ready flag until the downstream compute controller acknowledges the frame, then reloads.

Parameters:
- DATA_WIDTH, 17, width of each real and imaginary sample (two's complement, passed through unchanged).
- NUM_BANKS, 8, number of register-file banks; sets the width of wen_ctrl.
- BANK_DEPTH, 8, words per bank; waddr_ctrl is log2(BANK_DEPTH) = 3 bits.
- BIT_REVERSE, 0, 1 = write sample n to the bit-reversed 6-bit index.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  allows a new frame to start loading.
- in_valid  in  1  input sample valid.
- in_ready  out  1  loader can accept a sample.
- in_real  in  DATA_WIDTH  input sample, real part.
- in_imag  in  DATA_WIDTH  input sample, imaginary part.
- in_last  in  1  producer marks the final sample of its frame.
- wen_ctrl  out  NUM_BANKS  one-hot bank write enable.
- waddr_ctrl  out  3  word address within the bank.
- din_real  out  DATA_WIDTH  write data, real part.
- din_imag  out  DATA_WIDTH  write data, imaginary part.
- frame_valid  out  1  64 samples written; frame is available to compute.
- frame_ack  in  1  compute controller has taken the frame.
- sample_cnt  out  6  number of samples accepted in the current frame.
- err_len  out  1  sticky frame-length error.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state = IDLE.
  - in_ready, wen_ctrl, waddr_ctrl, din_real, din_imag, frame_valid, sample_cnt and err_len all = 0.
  - Reset mid-frame discards the partial frame; no further writes are issued.
- States:
  - IDLE: in_ready=0. Moves to LOAD on the cycle after enable=1.
  - LOAD: in_ready=1. An accept occurs on any cycle with in_valid & in_ready. Each accept increments sample_cnt. The accept with sample_cnt==63 moves the state to FULL and wraps sample_cnt to 0.
  - FULL: in_ready=0, frame_valid=1. On frame_ack=1, frame_valid clears on the next cycle; the next state is LOAD if enable=1, otherwise IDLE.
- frame_ack while not in FULL is ignored.
- Dropping enable mid-LOAD does not stop loading; the current frame completes.
- Write mapping for an accept at count n:
  - idx = BIT_REVERSE ? bitrev6(n) : n.
  - wen_ctrl = one-hot(idx[5:3]), waddr_ctrl = idx[2:0].
  - din = the accepted in_real/in_imag.
- Write latency is 1 cycle: all write outputs are registered and present the cycle after the accept.
- In any cycle without an accept, wen_ctrl = 0; waddr_ctrl and din hold their last values.
- Exactly one wen_ctrl bit is ever high; back-to-back accepts give back-to-back writes with no bubbles.
- err_len is set, and stays set until rst, when either:
  - in_last=1 on an accept with n≠63, or
  - in_last=0 on the accept with n==63.
- err_len does not alter framing: a frame is always exactly 64 samples.
- frame_valid rises on the same edge as the write of sample 63. The data array is therefore complete one cycle after frame_valid is first seen high.
- When frame_ack and in_valid arrive together in FULL, no sample is accepted that cycle, because in_ready=0.

Test Plan:
- Reset, enable=1, stream samples n=0..63 with real=imag=n, in_valid held high, in_last on n=63:
  - writes appear 1 cycle after each accept;
  - n=0 → wen_ctrl=8'h01, addr 0; n=12 → 8'h02, addr 4; n=63 → 8'h80, addr 7;
  - frame_valid=1 and in_ready=0 afterwards.
- BIT_REVERSE=1, same stream: n=1 → idx 32 → wen_ctrl=8'h10, addr 0; n=8 → idx 4 → wen_ctrl=8'h01, addr 4; n=9 → idx 36 → 8'h10, addr 4.
- in_valid toggled 1,0,1,0 during LOAD: wen_ctrl pulses only on accept cycles; sample_cnt steps 1,1,2,2.
- In FULL, hold frame_ack=0 for 10 cycles with in_valid=1: no writes, frame_valid stays 1. Then pulse frame_ack with enable=1: frame_valid=0 and in_ready=1 on the following cycle.
- in_last asserted on n=30: err_len=1 and stays 1; loading continues; frame_valid rises only after n=63.
- rst=1 after 20 accepted samples: all outputs return to 0 and state is IDLE. The next frame restarts with n=0 → wen_ctrl=8'h01, addr 0.
